router_dest_reader: RTL and testbench

ROUTER_DEST_READER -- requirements
Module: router_dest_reader

---
 rtl/router_dest_reader.sv | 102 ++++++++++
 tb/tb_router_dest_reader.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_dest_reader.sv
// router_dest_reader: reads header/payload/parity packets from a FIFO and streams them downstream.
// Define ROUTER_DEST_READER_STATS_EN to add saturating pkt_count/err_count outputs.
module router_dest_reader #(
   parameter int STALL_LIMIT = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       empty,
   input  logic [7:0] fifo_data,
   input  logic       dest_ready,
   output logic       read_en,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       is_header,
   output logic [5:0] pkt_len,
   output logic       busy,
   output logic       pkt_done,
   output logic       parity_err,
   output logic       timeout_err
`ifdef ROUTER_DEST_READER_STATS_EN
   ,
   output logic [15:0] pkt_count,
   output logic [15:0] err_count
`endif
);
   localparam int SW = $clog2(STALL_LIMIT + 1);
   typedef enum logic [2:0] {IDLE, RD_HDR, RD_PAYLOAD, RD_PARITY, CHECK} state_t;
   state_t state, state_nxt;
   logic [6:0] req_rem, cap_rem, hdr_rem;
   logic [7:0] par_acc, par_rx;
   logic [5:0] len_q;
   logic [SW-1:0] stall_cnt;
   logic rd_q, in_body, rd, starve, timeout, hdr_cap, body_cap;
   // req_rem tracks reads still to issue, cap_rem bytes still to arrive; they differ by the one in flight
   always_comb begin
      in_body = state == RD_PAYLOAD || state == RD_PARITY;
      rd = reset && !empty && dest_ready &&
           (state == IDLE || state == RD_HDR || (in_body && req_rem != 7'd0));
      hdr_cap = rd_q && state == RD_HDR;
      body_cap = rd_q && in_body && cap_rem != 7'd0;
      starve = in_body && empty && dest_ready;
      timeout = starve && stall_cnt == SW'(STALL_LIMIT - 1);
      hdr_rem = {1'b0, fifo_data[7:2]} + 7'd1 - {6'd0, rd};
      state_nxt = state;
      case (state)
         IDLE:       state_nxt = rd ? RD_HDR : IDLE;
         RD_HDR:     state_nxt = hdr_rem <= 7'd1 ? RD_PARITY : RD_PAYLOAD;
         RD_PAYLOAD: state_nxt = (rd && req_rem == 7'd2) ? RD_PARITY : RD_PAYLOAD;
         RD_PARITY:  state_nxt = (body_cap && cap_rem == 7'd1) ? CHECK : RD_PARITY;
         CHECK:      state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
      if (timeout) state_nxt = IDLE;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         rd_q      <= 1'b0;
         req_rem   <= '0;
         cap_rem   <= '0;
         par_acc   <= '0;
         par_rx    <= '0;
         len_q     <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nxt;
         rd_q  <= rd;
         stall_cnt <= (rd || !in_body || timeout) ? '0 : starve ? stall_cnt + 1'b1 : stall_cnt;
         if (hdr_cap) begin
            len_q   <= fifo_data[7:2];
            par_acc <= fifo_data;
            req_rem <= hdr_rem;
            cap_rem <= {1'b0, fifo_data[7:2]} + 7'd1;
         end else begin
            if (rd && in_body) req_rem <= req_rem - 7'd1;
            if (body_cap) begin
               cap_rem <= cap_rem - 7'd1;
               if (cap_rem == 7'd1) par_rx <= fifo_data;
               else par_acc <= par_acc ^ fifo_data;
            end
         end
      end
   assign read_en     = rd;
   assign is_header   = hdr_cap;
   assign byte_valid  = hdr_cap || (body_cap && cap_rem != 7'd1);
   assign byte_out    = byte_valid ? fifo_data : 8'h00;
   assign pkt_len     = len_q;
   assign busy        = state != IDLE || rd;
   assign pkt_done    = state == CHECK;
   assign parity_err  = pkt_done && par_acc != par_rx;
   assign timeout_err = timeout;
`ifdef ROUTER_DEST_READER_STATS_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pkt_count <= '0;
         err_count <= '0;
      end else begin
         if (pkt_done && !parity_err && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
         if ((parity_err || timeout_err) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
`endif
endmodule

// File: tb/tb_router_dest_reader.sv
// tb_router_dest_reader: randomized self-checking bench with a FIFO model and packet-level scoreboard.
module tb_router_dest_reader;
   localparam int LIMIT = 30;
   logic clk = 1'b0, reset = 1'b0, empty = 1'b1, dest_ready = 1'b0;
   logic [7:0] fifo_data = 8'h00;
   logic read_en, byte_valid, is_header, busy, pkt_done, parity_err, timeout_err;
   logic [7:0] byte_out;
   logic [5:0] pkt_len;
`ifdef ROUTER_DEST_READER_STATS_EN
   logic [15:0] pkt_count, err_count;
`endif
   int errors = 0, checks = 0;
   logic [7:0] fifo_q[$];
   logic [8:0] beats[$], exp_beats[$];
   logic dones[$], exp_dones[$];
   logic [7:0] nxt_data = 8'h00;
   logic nxt_vld = 1'b0, force_empty = 1'b1, rand_gaps = 1'b0, dr = 1'b1;
   int cyc = 0, hdr_cyc = 0, to_cyc = 0, timeouts = 0, bad_reads = 0, reads = 0, stray = 0;
   int exp_good = 0, exp_err = 0;

   router_dest_reader #(.STALL_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset), .empty(empty), .fifo_data(fifo_data), .dest_ready(dest_ready),
      .read_en(read_en), .byte_out(byte_out), .byte_valid(byte_valid), .is_header(is_header),
      .pkt_len(pkt_len), .busy(busy), .pkt_done(pkt_done), .parity_err(parity_err),
      .timeout_err(timeout_err)
`ifdef ROUTER_DEST_READER_STATS_EN
      , .pkt_count(pkt_count), .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   // one clock of the FIFO model; entered and left 1 time unit after a rising edge
   task automatic cycle();
      fifo_data = nxt_vld ? nxt_data : 8'($urandom);
      nxt_vld = 1'b0;
      empty = force_empty || fifo_q.size() == 0 || (rand_gaps && $urandom_range(0, 3) == 0);
      dest_ready = dr && !(rand_gaps && $urandom_range(0, 4) == 0);
      @(negedge clk);
      cyc++;
      if (read_en) reads++;
      if (read_en && empty) bad_reads++;
      if (read_en && fifo_q.size() > 0) begin
         nxt_data = fifo_q.pop_front();
         nxt_vld = 1'b1;
      end
      if (byte_valid) beats.push_back({is_header, byte_out});
      if (byte_valid && is_header) hdr_cyc = cyc;
      if (pkt_done) dones.push_back(parity_err);
      if (parity_err && !pkt_done) stray++;
      if (timeout_err) begin
         timeouts++;
         to_cyc = cyc;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      beats.delete();
      exp_beats.delete();
      dones.delete();
      exp_dones.delete();
      timeouts = 0;
   endtask

   // reference: header beat + payload beats shown, parity hidden, error if XOR(header,payload) != parity
   task automatic add_packet(input logic [7:0] b[$]);
      logic [7:0] x;
      int len;
      x = 8'h00;
      len = int'(b[0][7:2]);
      foreach (b[i]) fifo_q.push_back(b[i]);
      for (int i = 0; i <= len; i++) begin
         x ^= b[i];
         exp_beats.push_back({i == 0, b[i]});
      end
      exp_dones.push_back(x != b[len + 1]);
      if (x != b[len + 1]) exp_err++;
      else exp_good++;
   endtask

   task automatic rand_packet(input logic corrupt);
      logic [7:0] b[$];
      logic [5:0] len;
      logic [7:0] x;
      len = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(13, 63)) : 6'($urandom_range(0, 12));
      b.push_back({len, 2'($urandom)});
      x = b[0];
      for (int i = 0; i < int'(len); i++) begin
         b.push_back(8'($urandom));
         x ^= b[i + 1];
      end
      b.push_back(corrupt ? x ^ 8'($urandom_range(1, 255)) : x);
      add_packet(b);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      empty = 1'b0;
      dest_ready = 1'b1;
      fifo_data = 8'hA5;
      #1;
      checks++;
      if ({read_en, byte_out, byte_valid, is_header, pkt_len, busy, pkt_done, parity_err, timeout_err} !== 22'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", {read_en, byte_out, byte_valid, is_header, pkt_len, busy, pkt_done, parity_err, timeout_err});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({read_en, byte_out, byte_valid, busy, pkt_done} !== 12'd0) begin
         errors++;
         $display("FAIL reset_after_edge: got %h want 0", {read_en, byte_out, byte_valid, busy, pkt_done});
      end
      empty = 1'b1;
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || read_en !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b read_en=%b want 0 0", busy, read_en);
      end
   endtask

   task automatic test_vectors();
      logic [7:0] b[$];
      clear_logs();
      force_empty = 1'b0;
      rand_gaps = 1'b0;
      dr = 1'b1;
      b = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33};
      add_packet(b);
      b = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
      add_packet(b);
      b = {8'h01, 8'h01};
      add_packet(b);
      for (int k = 0; k < 100 && dones.size() < 3; k++) cycle();
      for (int k = 0; k < 4; k++) cycle();
      checks++;
      if (beats.size() != exp_beats.size()) begin
         errors++;
         $display("FAIL vec_beat_count: got %0d want %0d", beats.size(), exp_beats.size());
      end
      for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
         checks++;
         if (beats[i] !== exp_beats[i]) begin
            errors++;
            $display("FAIL vec_beat[%0d]: got %h want %h", i, beats[i], exp_beats[i]);
         end
      end
      checks++;
      if (dones.size() != 3) begin
         errors++;
         $display("FAIL vec_done_count: got %0d want 3", dones.size());
      end
      for (int i = 0; i < exp_dones.size() && i < dones.size(); i++) begin
         checks++;
         if (dones[i] !== exp_dones[i]) begin
            errors++;
            $display("FAIL vec_parity_err[%0d]: got %b want %b", i, dones[i], exp_dones[i]);
         end
      end
      checks++;
      if (busy !== 1'b0 || pkt_len !== 6'd0) begin
         errors++;
         $display("FAIL vec_idle: busy=%b pkt_len=%0d want 0 0", busy, pkt_len);
      end
   endtask

   task automatic test_timeout();
      clear_logs();
      force_empty = 1'b0;
      fifo_q.push_back(8'h0D);
      exp_err++;
      hdr_cyc = 0;
      to_cyc = 0;
      for (int k = 0; k < 80 && timeouts == 0; k++) cycle();
      for (int k = 0; k < 3; k++) cycle();
      checks++;
      if (timeouts != 1 || to_cyc - hdr_cyc != LIMIT) begin
         errors++;
         $display("FAIL timeout_pulse: pulses=%0d at_cycle=%0d want 1 at %0d", timeouts, to_cyc - hdr_cyc, LIMIT);
      end
      checks++;
      if (dones.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_abort: dones=%0d busy=%b want 0 0", dones.size(), busy);
      end
      checks++;
      if (beats.size() != 1 || beats[0] !== 9'h10D || pkt_len !== 6'd3) begin
         errors++;
         $display("FAIL timeout_header: beats=%0d pkt_len=%0d want 1 3", beats.size(), pkt_len);
      end
   endtask

   task automatic test_dest_stall();
      logic [7:0] b[$];
      int r0;
      clear_logs();
      force_empty = 1'b0;
      b = {8'h0E, 8'h5A, 8'hC3, 8'h7E, 8'h0E ^ 8'h5A ^ 8'hC3 ^ 8'h7E};
      add_packet(b);
      for (int k = 0; k < 20 && beats.size() < 2; k++) cycle();
      dr = 1'b0;
      force_empty = 1'b1;
      cycle();
      r0 = reads;
      for (int k = 0; k < 50; k++) cycle();
      checks++;
      if (reads != r0 || timeouts != 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL stall_hold: reads=%0d timeouts=%0d busy=%b want 0 0 1", reads - r0, timeouts, busy);
      end
      dr = 1'b1;
      force_empty = 1'b0;
      for (int k = 0; k < 40 && dones.size() < 1; k++) cycle();
      checks++;
      if (beats.size() != exp_beats.size()) begin
         errors++;
         $display("FAIL stall_beat_count: got %0d want %0d", beats.size(), exp_beats.size());
      end
      for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
         checks++;
         if (beats[i] !== exp_beats[i]) begin
            errors++;
            $display("FAIL stall_beat[%0d]: got %h want %h", i, beats[i], exp_beats[i]);
         end
      end
      checks++;
      if (dones.size() != 1 || dones[0] !== 1'b0) begin
         errors++;
         $display("FAIL stall_done: count=%0d want 1 with no error", dones.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b[$];
      clear_logs();
      force_empty = 1'b0;
      b = {8'h0D, 8'h44, 8'h55, 8'h66, 8'h0D ^ 8'h44 ^ 8'h55 ^ 8'h66};
      add_packet(b);
      for (int k = 0; k < 20 && beats.size() < 3; k++) cycle();
      empty = 1'b0;
      dest_ready = 1'b1;
      reset = 1'b0;
      #1;
      checks++;
      if ({read_en, byte_out, byte_valid, is_header, pkt_len, busy, pkt_done, parity_err, timeout_err} !== 22'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %h want 0", {read_en, byte_out, byte_valid, is_header, pkt_len, busy, pkt_done, parity_err, timeout_err});
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      fifo_q.delete();
      nxt_vld = 1'b0;
      exp_good = 0;
      exp_err = 0;
      clear_logs();
      b = {8'h09, 8'h80, 8'h07, 8'h09 ^ 8'h80 ^ 8'h07};
      add_packet(b);
      for (int k = 0; k < 40 && dones.size() < 1; k++) cycle();
      for (int k = 0; k < 2; k++) cycle();
      checks++;
      if (beats.size() != 3 || dones.size() != 1 || timeouts != 0) begin
         errors++;
         $display("FAIL reset_mid_next: beats=%0d dones=%0d timeouts=%0d want 3 1 0", beats.size(), dones.size(), timeouts);
      end
      for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
         checks++;
         if (beats[i] !== exp_beats[i]) begin
            errors++;
            $display("FAIL reset_mid_beat[%0d]: got %h want %h", i, beats[i], exp_beats[i]);
         end
      end
      checks++;
      if (dones.size() > 0 && dones[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_parity: got %b want 0", dones[0]);
      end
   endtask

   task automatic test_random();
      clear_logs();
      force_empty = 1'b0;
      rand_gaps = 1'b1;
      dr = 1'b1;
      for (int p = 0; p < 25; p++) rand_packet($urandom_range(0, 2) == 0);
      for (int k = 0; k < 8000 && dones.size() < 25; k++) cycle();
      rand_gaps = 1'b0;
      for (int k = 0; k < 3; k++) cycle();
      checks++;
      if (beats.size() != exp_beats.size() || dones.size() != 25 || timeouts != 0) begin
         errors++;
         $display("FAIL rand_counts: beats=%0d/%0d dones=%0d/25 timeouts=%0d", beats.size(), exp_beats.size(), dones.size(), timeouts);
      end
      for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
         checks++;
         if (beats[i] !== exp_beats[i]) begin
            errors++;
            $display("FAIL rand_beat[%0d]: got %h want %h", i, beats[i], exp_beats[i]);
         end
      end
      for (int i = 0; i < exp_dones.size() && i < dones.size(); i++) begin
         checks++;
         if (dones[i] !== exp_dones[i]) begin
            errors++;
            $display("FAIL rand_parity_err[%0d]: got %b want %b", i, dones[i], exp_dones[i]);
         end
      end
   endtask

`ifdef ROUTER_DEST_READER_STATS_EN
   task automatic test_stats();
      checks++;
      if (pkt_count !== 16'(exp_good) || err_count !== 16'(exp_err)) begin
         errors++;
         $display("FAIL stats: pkt_count=%0d err_count=%0d want %0d %0d", pkt_count, err_count, exp_good, exp_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_vectors();
      test_timeout();
      test_dest_stall();
      test_reset_mid();
      test_random();
`ifdef ROUTER_DEST_READER_STATS_EN
      test_stats();
`endif
      checks++;
      if (bad_reads != 0 || stray != 0) begin
         errors++;
         $display("FAIL protocol: reads_while_empty=%0d parity_err_without_done=%0d want 0 0", bad_reads, stray);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
